fft_iter_loader: RTL
====================

FFT_ITER_LOADER -- requirements
Module: fft_iter_loader

Interface
REQ-001 SHALL have parameter IWL, default 32, complex sample width (re in [IWL-1:IWL/2], im in [IWL/2-1:0]).
REQ-002 SHALL have parameter AWL, default 7, FFT RAM address width; frame length N = 2^AWL samples.
REQ-003 SHALL have parameter BITREV, default 1, 1 = write samples at bit-reversed addresses, 0 = natural order.
REQ-004 SHALL have parameter TMO, default 16, max cycles from START pulse to i_RAM_BLOCK rising.
REQ-005 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port EN  input  1  clock enable; 0 freezes all state.
REQ-008 SHALL have port i_DATA  input  IWL  input sample.
REQ-009 SHALL have port i_VALID  input  1  i_DATA valid.
REQ-010 SHALL have port o_READY  output  1  loader accepts a sample this cycle.
REQ-011 SHALL have ports o_A_DATA, o_B_DATA  output  IWL  RAM write data, ports A and B.
REQ-012 SHALL have ports o_A_ADDR, o_B_ADDR  output  AWL  RAM write addresses.
REQ-013 SHALL have port o_RAM_Wr  output  1  dual-port write strobe.
REQ-014 SHALL have port o_START  output  1  one-cycle FFT start pulse.
REQ-015 SHALL have port i_RAM_BLOCK  input  1  FFT core busy / RAM locked.
REQ-016 SHALL have ports o_BUSY, o_DONE, o_ERR  output  1 each  frame in progress, one-cycle frame-complete pulse, sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, KICK, WAIT_BLK, RUN, DONE.
REQ-018 IDLE -> LOAD when EN=1, i_RAM_BLOCK=0, o_ERR=0; sample counter cleared.
REQ-019 o_READY SHALL be 1 only in LOAD with EN=1; a sample is accepted on i_VALID && o_READY.
REQ-020 Samples pair up: even-index sample held in register; odd-index acceptance drives o_RAM_Wr=1 for that same cycle (combinational from the handshake) with o_A_DATA=held, o_B_DATA=i_DATA.
REQ-021 For pair k: o_A_ADDR=f(2k), o_B_ADDR=f(2k+1), f = AWL-bit reversal if BITREV=1, identity otherwise.
REQ-022 Gaps in i_VALID SHALL stall loading without loss; a held even sample is kept indefinitely.
REQ-023 After write of pair N/2-1: LOAD -> KICK; o_READY=0 from the next cycle.
REQ-024 KICK: o_START=1 for exactly one cycle, then -> WAIT_BLK with timeout counter cleared.
REQ-025 WAIT_BLK: i_RAM_BLOCK=1 -> RUN; if TMO cycles elapse without it, set o_ERR=1, -> IDLE.
REQ-026 RUN: i_RAM_BLOCK=0 -> DONE; no timeout in RUN.
REQ-027 DONE: o_DONE=1 one cycle, -> IDLE; next frame may begin the following cycle.
REQ-028 o_BUSY SHALL be 1 in every state except IDLE.
REQ-029 o_ERR clears only on RST; while set, FSM stays in IDLE.
REQ-030 EN=0: state, counters, held sample frozen; o_READY, o_RAM_Wr, o_START forced 0; a KICK pulse is deferred, not lost.
REQ-031 i_RAM_BLOCK=1 in IDLE (foreign owner) SHALL hold the FSM in IDLE.

Reset
REQ-032 RST SHALL force IDLE, counters 0, held sample 0, o_ERR=0; outputs o_READY, o_RAM_Wr, o_START, o_BUSY, o_DONE = 0; data/address outputs = 0.
REQ-033 RST mid-frame SHALL abandon the partial frame; no further RAM writes or START until a new frame.
REQ-034 RST SHALL take priority over EN.

Structure
REQ-035 FSM state encodings and the bit-reverse function SHALL live in shared package fft_pkg.
REQ-036 Timeout counter width SHALL be clog2(TMO+1); sample counter width AWL.
REQ-037 One sub-module is natural: fft_addr_gen (pair index -> two AWL-bit addresses, BITREV-aware).

Verification (AWL=3, N=8, IWL=32)
REQ-038 BITREV=0, samples 0x00010000..0x00080000 continuous -> 4 writes, addrs (0,1),(2,3),(4,5),(6,7), then o_START one cycle.
REQ-039 BITREV=1, same stimulus -> addr pairs (0,4),(2,6),(1,5),(3,7), data unchanged in order.
REQ-040 i_VALID toggling 1/0 every cycle -> identical write contents, 8 writes-worth in 16 cycles, no drops.
REQ-041 Model raises i_RAM_BLOCK 2 cycles after START, holds 20 cycles -> o_DONE one cycle after fall, o_BUSY low next cycle.
REQ-042 TMO=16, i_RAM_BLOCK never rises -> o_ERR=1 exactly 16 cycles after START, FSM IDLE, o_READY stays 0 until RST.
REQ-043 RST asserted after 5 samples -> all outputs 0 next cycle; fresh 8-sample frame writes from address 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Purpose : shared FSM state encoding and bit-reverse helper for the FFT frame loader.
// Latency : n/a (types and a pure combinational function).
// Backpressure : n/a.
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_KICK     = 3'd2,
    ST_WAIT_BLK = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Reverses the low 'width' bits of val; bits at and above 'width' come back zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] val, input int width);
    logic [31:0] r;
    int          src;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        src         = width - 1 - i;
        r[i[4:0]]   = val[src[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_iter_loader_if.sv
// Purpose : sample-stream and RAM write-port bundle between the frame loader and its neighbours.
// Latency : n/a (wires only).
// Backpressure : o_READY qualifies i_VALID; i_RAM_BLOCK is the FFT core's busy/lock indication.
// Ports   : i_DATA/i_VALID/o_READY sample stream; o_A_*/o_B_*/o_RAM_Wr dual-port RAM write;
//           o_START FFT kick; i_RAM_BLOCK core busy.  master = loader side, slave = environment side.
interface fft_iter_loader_if #(
  parameter int IWL = 32,
  parameter int AWL = 7
);
  logic [IWL-1:0] i_DATA;
  logic           i_VALID;
  logic           o_READY;
  logic [IWL-1:0] o_A_DATA;
  logic [IWL-1:0] o_B_DATA;
  logic [AWL-1:0] o_A_ADDR;
  logic [AWL-1:0] o_B_ADDR;
  logic           o_RAM_Wr;
  logic           o_START;
  logic           i_RAM_BLOCK;

  modport master (
    input  i_DATA, i_VALID, i_RAM_BLOCK,
    output o_READY, o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR, o_RAM_Wr, o_START
  );

  modport slave (
    output i_DATA, i_VALID, i_RAM_BLOCK,
    input  o_READY, o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR, o_RAM_Wr, o_START
  );
endinterface

// File: rtl/fft_addr_gen.sv
// Purpose : maps a sample-pair index to the two RAM addresses of that pair (natural or bit-reversed).
// Latency : combinational, zero cycles.
// Backpressure : none; pure function of i_PAIR.
// Ports   : i_PAIR pair index k; o_A_ADDR = f(2k), o_B_ADDR = f(2k+1).
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int AWL    = 7,
  parameter bit BITREV = 1'b1
) (
  input  logic [AWL-2:0] i_PAIR,
  output logic [AWL-1:0] o_A_ADDR,
  output logic [AWL-1:0] o_B_ADDR
);

  logic [AWL-1:0] w_a_nat;
  logic [AWL-1:0] w_b_nat;

  assign w_a_nat = {i_PAIR, 1'b0};
  assign w_b_nat = {i_PAIR, 1'b1};

  always_comb begin
    o_A_ADDR = w_a_nat;
    o_B_ADDR = w_b_nat;
    if (BITREV) begin
      o_A_ADDR = AWL'(bit_rev(32'(w_a_nat), AWL));
      o_B_ADDR = AWL'(bit_rev(32'(w_b_nat), AWL));
    end
  end

endmodule

// File: rtl/fft_iter_loader.sv
// Purpose : collects N=2^AWL samples into FFT RAM two at a time, then kicks the core and tracks it.
// Latency : RAM write is combinational with the odd-sample handshake; START one cycle after last write.
// Backpressure : o_READY only in LOAD with EN=1; i_VALID gaps stall loading, held sample kept.
// Ports   : CLK/RST (sync, active-high)/EN clock enable; io_bus stream + RAM port;
//           o_BUSY frame in progress, o_DONE one-cycle completion, o_ERR sticky start timeout.
module fft_iter_loader
  import fft_pkg::*;
#(
  parameter int IWL    = 32,
  parameter int AWL    = 7,
  parameter bit BITREV = 1'b1,
  parameter int TMO    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  fft_iter_loader_if.master io_bus,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_ERR
);

  localparam int TW = $clog2(TMO + 1);
  // The START cycle is the first cycle of the timeout budget, so the WAIT_BLK
  // cycle holding counter value v is cycle v+1 after START.  Flagging at
  // v = TMO-2 makes o_ERR appear exactly TMO cycles after START.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 2);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AWL-1:0] r_cnt;
  logic [AWL-1:0] w_cnt_nxt;
  logic [IWL-1:0] r_hold;
  logic [IWL-1:0] w_hold_nxt;
  logic [TW-1:0]  r_tmo;
  logic [TW-1:0]  w_tmo_nxt;
  logic           r_err;
  logic           w_err_nxt;

  logic           w_run;
  logic           w_ready;
  logic           w_wr;
  logic           w_start;
  logic           w_done;
  logic [AWL-1:0] w_a_addr;
  logic [AWL-1:0] w_b_addr;

  // Strobes are suppressed while frozen and also during a reset cycle, so a
  // reset mid-frame cannot let one last write or START slip out.
  assign w_run = EN & ~RST;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else if (EN) begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, held even sample and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_hold <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else if (EN) begin
      r_cnt  <= w_cnt_nxt;
      r_hold <= w_hold_nxt;
      r_tmo  <= w_tmo_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_ready     = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        // A raised i_RAM_BLOCK here belongs to someone else; keep out of the RAM.
        if (!io_bus.i_RAM_BLOCK && !r_err) begin
          w_state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        w_ready = w_run;
        if (w_ready && io_bus.i_VALID) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (!r_cnt[0]) begin
            w_hold_nxt = io_bus.i_DATA;
          end else if (&r_cnt) begin
            w_state_nxt = ST_KICK;
          end
        end
      end

      ST_KICK: begin
        // With EN=0 the state does not advance, so the pulse waits for EN.
        w_start     = w_run;
        w_tmo_nxt   = '0;
        w_state_nxt = ST_WAIT_BLK;
      end

      ST_WAIT_BLK: begin
        if (io_bus.i_RAM_BLOCK) begin
          w_state_nxt = ST_RUN;
        end else if (r_tmo == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      ST_RUN: begin
        if (!io_bus.i_RAM_BLOCK) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_done      = w_run;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Odd-index acceptance completes a pair and writes both RAM ports at once.
  assign w_wr = w_ready & io_bus.i_VALID & r_cnt[0];

  fft_addr_gen #(
    .AWL    (AWL),
    .BITREV (BITREV)
  ) u_addr_gen (
    .i_PAIR   (r_cnt[AWL-1:1]),
    .o_A_ADDR (w_a_addr),
    .o_B_ADDR (w_b_addr)
  );

  // Data/address outputs are zero unless a write is in progress, so the RAM
  // port is quiet in reset and between pairs.
  assign io_bus.o_READY  = w_ready;
  assign io_bus.o_RAM_Wr = w_wr;
  assign io_bus.o_A_DATA = w_wr ? r_hold        : '0;
  assign io_bus.o_B_DATA = w_wr ? io_bus.i_DATA : '0;
  assign io_bus.o_A_ADDR = w_wr ? w_a_addr      : '0;
  assign io_bus.o_B_ADDR = w_wr ? w_b_addr      : '0;
  assign io_bus.o_START  = w_start;

  assign o_BUSY = (r_state != ST_IDLE) & ~RST;
  assign o_DONE = w_done;
  assign o_ERR  = r_err;

endmodule
